popcnt_unit: RTL
================

# popcnt_unit

Multi-cycle population-count unit for the CPU's execute stage. It accepts a 32-bit operand with a start pulse and counts set bits (or clear bits) six bits per cycle through a single 6-bit popcount slice. It reports completion with a `busy`/`done` handshake, so the pipeline stalls on it the same way it stalls on the multiply/divide unit. It schedules the shared slice across the six chunks of the word and accumulates the partial sums.

## Interface
- `WIDTH`, default 32: operand width; fixed at 32 in this design, the slice count is derived from it.
- `SLICE`, default 6: bits counted per cycle; width of the popcount slice.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a count; sampled on `clk` rising edge; accepted only when `busy`=0.
- `op`, input, 1: 0 = count ones, 1 = count zeros; sampled with `start`.
- `data`, input, 32: operand; sampled with `start`.
- `busy`, output, 1: high while a count is in progress.
- `done`, output, 1: one-cycle pulse when `result` has just been updated.
- `result`, output, 6: count, 0..32; holds its value until the next completion.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: counting, one chunk per cycle.
  - DONE: reporting completion for one cycle.
- Registers:
  - `shreg` (36 bits): operand plus zero padding.
  - `idx` (3 bits): chunk counter.
  - `acc` (6 bits): running count.
  - `result` (6 bits): output count.
  - `state`: current state.
- Accepting a request (`start`=1 with state IDLE or DONE):
  - Load `shreg` = {4'b0, `op` ? ~`data` : `data`}. Padding is applied after inversion, so the pad bits never count.
  - Clear `acc` and `idx`; go to RUN.
- Each RUN cycle:
  - `acc` ← `acc` + pop6(`shreg[5:0]`).
  - `shreg` ← `shreg` >> 6.
  - `idx` ← `idx` + 1.
  - When `idx`=5: write `result` ← `acc` + pop6(`shreg[5:0]`) and go to DONE.
- DONE lasts one cycle, then returns to IDLE unless a new `start` is accepted in that cycle.
- Outputs: `busy` = (state==RUN); `done` = (state==DONE).
- Width rules:
  - The maximum count is 32, which fits in 6 bits; there is no overflow.
  - The accumulator adds the slice output zero-extended to 6 bits.
- Boundary conditions:
  - `start` while `busy`=1 is ignored; `data` and `op` are not sampled.
  - `start` in the DONE cycle is accepted (back-to-back). `done` still pulses for the finishing count, and `busy` rises next cycle.
  - `reset` has priority over everything, including a mid-RUN count: state → IDLE, `busy`=0, `done`=0, `result`=0, `acc`=0, `idx`=0, `shreg`=0. A count in progress is discarded.
  - `reset` and `start` in the same cycle: reset wins; the request is dropped.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0.
- `start` is sampled at edge E0. Cycles 1–6 after E0 are RUN with `busy`=1. Cycle 7 is DONE with `done`=1, `busy`=0, and the new `result` visible.
- Latency from the `start` edge to the `done` pulse is 7 cycles. Throughput is one count per 7 cycles with back-to-back starts.
- `result` changes only at the edge entering DONE, or on reset.

## Structure
- Shared package/header holds:
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - `OP_ONES`=1'b0, `OP_ZEROS`=1'b1.
  - `NCHUNK`=6 (ceil(32/6)) and `LAST_IDX`=3'd5.
- Sub-module `pop6`: purely combinational 6-bit-in, 3-bit-out popcount slice, instantiated once.
- Top level: FSM, shift register, counter and accumulator.

## Test plan
- Reset, then `start`, `data`=32'hFFFFFFFF, `op`=0 → `busy`=1 for cycles 1–6; `done`=1 and `result`=32 in cycle 7.
- `data`=32'hFFFFFFFF, `op`=1 → `result`=0. Then `data`=32'h00000000, `op`=1 → `result`=32 (pad bits not counted).
- `data`=32'h80000001, `op`=0 → `result`=2. Then `data`=32'h0F0F00F3, `op`=0 → `result`=14.
- `start` with `data`=32'h00000007, then `start` again in cycle 3 with `data`=32'hFFFFFFFF → second request ignored; `result`=3 at cycle 7.
- `start` held high in the DONE cycle with new `data`=32'h00000001 → first `done` pulse with its result, `busy` rises the next cycle, second `done` 7 cycles later with `result`=1.
- `reset` asserted in cycle 4 of a count → next cycle `busy`=0, `done`=0, `result`=0. No `done` pulse follows; a fresh `start` then completes normally.

Source files
------------

// File: rtl/popcnt_unit_pkg.sv
// Shared constants for the multi-cycle population-count unit:
// FSM encodings, operation select values and chunk scheduling limits.
package popcnt_unit_pkg;

  // FSM encodings, kept as plain constants for legacy tool compatibility
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operation select carried on the op input
  localparam logic OP_ONES  = 1'b0;
  localparam logic OP_ZEROS = 1'b1;

  // A 32-bit operand is covered by ceil(32/6) = 6 slice passes
  localparam int         NCHUNK   = 6;
  localparam logic [2:0] LAST_IDX = 3'd5;

endpackage : popcnt_unit_pkg

// File: rtl/popcnt_unit_pop6.sv
// Combinational 6-bit population count slice shared by every chunk pass.
module popcnt_unit_pop6 (
  input  logic [5:0] bits,
  output logic [2:0] count
);

  // Sum the six input bits
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred,
    // and blocking '=' is correct here because this is combinational logic.
    count = '0;
    for (int i = 0; i < 6; i++) begin
      count = count + {2'b00, bits[i]};
    end
  end

endmodule : popcnt_unit_pop6

// File: rtl/popcnt_unit.sv
// Multi-cycle popcount for the execute stage. One shared 6-bit slice is
// applied to successive chunks of the (optionally inverted) operand; the
// partial sums accumulate and the total is published with a busy/done
// handshake so the pipeline can stall on it like the mul/div unit.
module popcnt_unit
  import popcnt_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [5:0]       result
);

  // Shift register spans all chunks; bits above WIDTH are zero padding
  localparam int SHW = NCHUNK * SLICE;

  logic [1:0]     state;
  logic [SHW-1:0] shreg;
  logic [2:0]     idx;
  logic [5:0]     acc;

  logic [2:0]       slice_cnt;
  logic [5:0]       slice_ext;
  logic [WIDTH-1:0] operand;
  logic             accept;

  popcnt_unit_pop6 u_pop6 (
    .bits  (shreg[SLICE-1:0]),
    .count (slice_cnt)
  );

  // Operand selection and request acceptance; padding is added after
  // inversion so the pad bits never contribute to a zero count
  always_comb begin
    slice_ext = {3'b000, slice_cnt};
    operand   = (op == OP_ONES) ? data : ~data;
    accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
  end

  // FSM, shift register, chunk counter, accumulator and result register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register sees
    // the pre-edge values of the others, independent of statement order.
    if (reset) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      idx    <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            shreg <= {{(SHW-WIDTH){1'b0}}, operand};
            acc   <= '0;
            idx   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc   <= acc + slice_ext;
          shreg <= shreg >> SLICE;
          idx   <= idx + 3'd1;
          if (idx == LAST_IDX) begin
            result <= acc + slice_ext;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode directly from state
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

endmodule : popcnt_unit
